// File: rtl/hw_stream_source_pkg.sv
// Shared types for the buffered stream source.
// State encoding and default word width.
package hw_stream_pkg;

  typedef enum logic [1:0] {
    LOAD,
    READY,
    DONE
  } hw_stream_state_t;

  localparam int HW_STREAM_DATA_W = 16;

endpackage

// File: rtl/hw_stream_source_sram.sv
// Simple dual-port buffer: one write port, one registered read port.
// The registered read gives the stream its one-cycle latency.
module hw_stream_sram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hw_stream_source.sv
// Buffered stream source: load once, then replay the buffer
// NUM_PASSES times, one word per read_en.
module hw_stream_source
  import hw_stream_pkg::*;
#(
  parameter int DATA_W     = HW_STREAM_DATA_W,
  parameter int DEPTH      = 1024,
  parameter int NUM_WORDS  = 1024,
  parameter int NUM_PASSES = 1,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              loaded,
  output logic              done,
  output logic              underrun,
  output logic [15:0]       pass_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_WORDS - 1);

  hw_stream_state_t  state_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_valid;
  logic [DATA_W-1:0] rdata;
  logic              flush_eff;
  logic              wr_fire;
  logic              rd_fire;
  logic              last_rd;
  logic              last_pass;
  logic [15:0]       pass_next;

  assign load_ready = (state_q == LOAD);
  assign flush_eff  = flush && (state_q != LOAD);
  assign wr_fire    = load_valid && load_ready;
  assign rd_fire    = read_en && (state_q == READY)
                      && !flush_eff;
  assign last_rd    = (rd_ptr == LAST_ADDR);
  assign pass_next  = (pass_count == 16'hFFFF) ?
                      pass_count : pass_count + 16'd1;
  assign last_pass  = ({16'd0, pass_count} + 32'd1)
                      == 32'(NUM_PASSES);

  // rdata has no reset; rd_valid masks it to zero until
  // the first real read after reset.
  assign read_data = rd_valid ? rdata : '0;

  hw_stream_sram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (load_data),
    .re    (rd_fire),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass_count <= '0;
      rd_valid   <= 1'b0;
      loaded     <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else if (flush_eff) begin
      state_q    <= READY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass_count <= '0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (read_en) underrun <= 1'b1;
          if (wr_fire) begin
            if (wr_ptr == LAST_ADDR) begin
              wr_ptr  <= '0;
              state_q <= READY;
              loaded  <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        READY: begin
          if (rd_fire) begin
            rd_valid <= 1'b1;
            if (last_rd) begin
              rd_ptr     <= '0;
              pass_count <= pass_next;
              if (last_pass) begin
                state_q <= DONE;
                done    <= 1'b1;
              end
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        DONE: begin
          if (read_en) underrun <= 1'b1;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/hw_stream_source.md
Name: hw_stream_source

Overview:
- Buffered stream source that feeds a compute kernel's `*_global_wrapper_stencil_read_en` / `*_stencil_read` port pair, e.g. the input or kernel stream of `resnet`.
- Loaded once through a valid/ready write port, then serves words in load order, one per `read_en`.
- Replays the buffer a programmable number of passes, which covers weight reuse.
- Replaces behavioural counter feeders in benches and serves as the on-chip loader in FPGA builds.

Parameters:
- DATA_W, 16, stream word width.
- DEPTH, 1024, buffer capacity in words.
- NUM_WORDS, 1024, words per pass; 1 <= NUM_WORDS <= DEPTH.
- NUM_PASSES, 1, full replays before done; >= 1.
- ADDR_W, $clog2(DEPTH), derived pointer width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous rewind: pointers and pass count return to 0, buffer contents kept.
- load_valid  in  1  load word present.
- load_ready  out  1  block accepts load words.
- load_data  in  DATA_W  load word.
- read_en  in  1  consumer requests next word.
- read_data  out  DATA_W  registered stream word.
- loaded  out  1  buffer holds NUM_WORDS words.
- done  out  1  all passes served.
- underrun  out  1  sticky: read_en arrived while no data was servable.
- pass_count  out  16  completed passes, saturating.

Behaviour:
- Reset values: state LOAD, wr_ptr 0, rd_ptr 0, pass_count 0, read_data 0, loaded 0, done 0, underrun 0, load_ready 1.
- States: LOAD, READY, DONE.
- LOAD:
  - load_ready = 1.
  - A word is written when load_valid && load_ready: mem[wr_ptr] <= load_data, wr_ptr++.
  - The write with wr_ptr == NUM_WORDS-1 moves to READY on the next cycle; from that cycle load_ready = 0 and loaded = 1.
  - load_valid outside LOAD is ignored.
- READY, read_en = 1:
  - read_data <= mem[rd_ptr] at that edge, so data is valid the cycle after read_en. Latency 1.
  - read_data holds whenever read_en = 0.
  - rd_ptr increments. On rd_ptr == NUM_WORDS-1 it wraps to 0 and pass_count increments.
  - If that wrap completes pass NUM_PASSES, the state moves to DONE and done = 1 from the next cycle.
- Back-to-back read_en: one word per cycle, no bubbles, including across the pass-wrap boundary.
- DONE:
  - done holds until rst or flush.
  - read_en sets underrun; read_data holds its last value.
- read_en in LOAD: sets underrun; read_data unchanged; no pointer movement.
- flush:
  - In READY or DONE: go to READY; rd_ptr 0, pass_count 0, done 0. underrun is unchanged.
  - In LOAD: flush has no effect.
  - Has priority over a same-cycle read_en. The read is dropped, no underrun is recorded, and read_data holds.
- rst has priority over flush and everything else. rst mid-load or mid-stream restarts in LOAD; buffer contents are don't-care.
- pass_count saturates at 16'hFFFF.
- No arithmetic on data; words pass through bit-exact.

Decomposition:
- Package hw_stream_pkg:
  - state enum hw_stream_state_t {LOAD, READY, DONE};
  - localparam default DATA_W.
- One sub-module, hw_stream_sram:
  - simple dual-port, 1 write / 1 registered read;
  - parameters DATA_W, DEPTH;
  - ports clk, we, waddr, wdata, re, raddr, rdata.
  - Its registered read provides the 1-cycle latency. The top-level FSM and pointers stay in hw_stream_source.

Test Plan (DEPTH=8, NUM_WORDS=4, NUM_PASSES=2 unless noted):
1. Load 10,11,12,13 with load_valid held high. → load_ready falls the cycle after the 4th accept; loaded=1. A 5th word (99) is ignored.
2. After load, read_en high for 8 consecutive cycles. → read_data = 10,11,12,13,10,11,12,13 on the 8 cycles following each request. pass_count goes 1 then 2; done=1 the cycle after the 8th read; underrun=0.
3. Pulse read_en once in LOAD and once in DONE. → underrun=1 and stays set; read_data unchanged (0 and 13 respectively).
4. Mid-stream, after 2 reads: flush and read_en in the same cycle. → read_data holds 11; the next read returns 10; pass_count=0; underrun stays 0.
5. Flush in DONE, then 4 reads. → done=0; data 10..13; buffer was not reloaded.
6. rst asserted while wr_ptr=2 during load. → all outputs at reset values next cycle; load_ready=1. A fresh load of 4 words then streams correctly.
